alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decoder in the RV32I core.
- Consumes the 3-bit ALUControl code plus operands, computes the result and flags, and holds them in a small elastic output buffer.
- Uses valid/ready handshakes on both sides so that memory/writeback stalls can back-pressure the decode side.
- Also keeps a saturating count of illegal ALUControl codes for debug.

Parameters:
- WIDTH, 32, operand/result width in bits.
- DEPTH, 2, output buffer entries (power of two, ≥2).
- CNT_W, 8, illegal-op counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline flush (branch redirect).
- in_valid  input  1  upstream presents an operation.
- in_ready  output  1  stage can accept this cycle.
- ALUControl  input  3  op code: 000 add, 001 sub, 010 and, 011 or, 101 slt; 100/110/111 illegal.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B.
- rd_in  input  5  destination register tag, carried through unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- ALUResult  output  WIDTH  head result.
- Zero  output  1  head result == 0.
- Overflow  output  1  signed overflow of head add/sub; 0 for other ops.
- rd_out  output  5  head tag.
- illegal_cnt  output  CNT_W  saturating count of accepted illegal ops.

Behaviour:
- Reset (rst low, asynchronous):
  - count, read/write pointers and illegal_cnt clear to 0.
  - out_valid = 0; ALUResult, Zero, Overflow and rd_out read 0.
  - in_ready = 1 after reset release.
- Accept and pop:
  - Accept = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = (count != DEPTH). It depends only on registered state, never combinationally on out_ready.
  - out_valid = (count != 0).
  - Outputs are driven from the head entry (registered), with no combinational path from inputs to outputs.
- Latency: an op accepted at edge N is visible on the outputs after edge N. With an empty buffer and out_ready high, throughput is 1 op/cycle.
- Arithmetic, computed on accept and stored with the entry:
  - add: A+B, modulo 2^WIDTH. sub: A−B, modulo 2^WIDTH.
  - and: A&B. or: A|B.
  - slt: signed A<B gives 1, else 0, zero-extended.
  - Overflow for add: sign(A)==sign(B) and sign(R)!=sign(A).
  - Overflow for sub: sign(A)!=sign(B) and sign(R)!=sign(A).
  - Zero is computed from the stored result.
- Illegal codes:
  - Result = 0, Zero = 1, Overflow = 0; the entry is still enqueued.
  - illegal_cnt increments on accept and saturates at all-ones.
- Push and pop in the same cycle: count is unchanged and both pointers advance, wrapping modulo DEPTH. When full, in_ready = 0, so a simultaneous pop does not admit a new op that cycle.
- Full: in_ready low and the buffer contents hold. Empty: out_valid low and out_ready is ignored.
- Flush (sampled at the clock edge):
  - count and pointers clear to 0 and any same-cycle accept is discarded.
  - illegal_cnt is NOT cleared, but an illegal op accepted in the flush cycle is not counted.
  - Flush has priority over push and pop.
- Reset mid-operation: all entries are lost and outputs return to reset values immediately.
- Upstream rule: once in_valid is asserted, ALUControl, SrcA, SrcB and rd_in must be held stable until accepted.

Test Plan:
- Single add: A=0x7FFFFFFF, B=1, ctl=000, out_ready=1 → next cycle ALUResult=0x80000000, Overflow=1, Zero=0, out_valid=1 for exactly one cycle.
- Sub and slt: A=5, B=5, ctl=001 → Result=0, Zero=1. Then A=0xFFFFFFFF, B=1, ctl=101 → Result=1.
- Back-pressure:
  - Hold out_ready=0 and push 3 ops (and 0xF0&0x3C, or 0xF0|0x0F, add 2+3).
  - After two accepts in_ready=0 and the third op is held.
  - Raise out_ready → pops give 0x30, 0xFF, 5 in order, with tags preserved.
- Streaming: in_valid=out_ready=1 for 8 cycles with incrementing operands → 8 results in order, one per cycle, and pointers wrap correctly.
- Illegal op and flush:
  - ctl=110 → Result=0, illegal_cnt=1.
  - With 2 entries buffered, assert flush together with in_valid → out_valid=0 next cycle, in_ready=1, nothing enqueued, illegal_cnt unchanged.
- Async reset: drop rst between clock edges while the buffer is full → out_valid and illegal_cnt go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: computes result/overflow on accept and parks it in a small
// elastic FIFO so writeback stalls back-pressure decode without combinational paths.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       rd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic [4:0]       rd_out,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic [4:0]       rd;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          nxt, head;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] sum, diff;
  logic            illegal, push, pop;

  always_comb begin
    sum     = SrcA + SrcB;
    diff    = SrcA - SrcB;
    nxt     = '0;
    nxt.rd  = rd_in;
    illegal = 1'b0;
    case (ALUControl)
      3'b000: begin
        nxt.res = sum;
        nxt.ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b001: begin
        nxt.res = diff;
        nxt.ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      3'b010:  nxt.res = SrcA & SrcB;
      3'b011:  nxt.res = SrcA | SrcB;
      3'b101:  nxt.res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      default: illegal = 1'b1;
    endcase
  end

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head is gated by occupancy so reset/flush present all-zero outputs.
  assign head      = mem[rptr];
  assign ALUResult = out_valid ? head.res : '0;
  assign Zero      = out_valid && (head.res == '0);
  assign Overflow  = out_valid && head.ovf;
  assign rd_out    = out_valid ? head.rd : '0;

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && illegal && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: queue-based reference model checked every
// negedge, plus literal expectations from hand-worked vectors.
module tb_alu_exec_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic             in_ready, out_valid, Zero, Overflow;
  logic [2:0]       ALUControl = '0;
  logic [WIDTH-1:0] SrcA = '0, SrcB = '0, ALUResult;
  logic [4:0]       rd_in = '0, rd_out;
  logic [CNT_W-1:0] illegal_cnt;

  int n_chk = 0, n_fail = 0;

  alu_exec_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .Zero(Zero), .Overflow(Overflow), .rd_out(rd_out), .illegal_cnt(illegal_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] res; bit ovf; logic [4:0] rd; } ent_t;
  ent_t q[$];
  int   m_cnt = 0;

  function automatic void calc(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] r, output bit v);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s  = 0;
    r = '0; v = 0;
    case (c)
      3'd0: s = sa + sb;
      3'd1: s = sa - sb;
      default: s = 0;
    endcase
    case (c)
      3'd0, 3'd1: begin
        r = s[31:0];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit acc, pp;
      ent_t e;
      acc = in_valid && (q.size() != DEPTH);
      pp  = out_ready && (q.size() != 0);
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          calc(ALUControl, SrcA, SrcB, e.res, e.ovf);
          e.rd = rd_in;
          q.push_back(e);
          if (ALUControl inside {3'd4, 3'd6, 3'd7} && m_cnt < 255) m_cnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("m_out_valid", out_valid, q.size() != 0);
      chk("m_in_ready", in_ready, q.size() != DEPTH);
      chk("m_illegal_cnt", illegal_cnt, m_cnt);
      if (q.size() != 0) begin
        chk("m_result", ALUResult, q[0].res);
        chk("m_zero", Zero, q[0].res == 0);
        chk("m_ovf", Overflow, q[0].ovf);
        chk("m_rd", rd_out, q[0].rd);
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    bit ok;
    int n = 0;
    ALUControl = c; SrcA = a; SrcB = b; rd_in = rd; in_valid = 1;
    do begin
      ok = in_ready;
      @(negedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_illegal", illegal_cnt, 0);
    @(negedge clk); @(negedge clk); rst = 1; #1;
    chk("rst_in_ready", in_ready, 1);

    // single add with overflow, visible for exactly one cycle
    out_ready = 1;
    send(3'd0, 32'h7FFF_FFFF, 32'h1, 5'd3);
    chk("add_valid", out_valid, 1);
    chk("add_result", ALUResult, 32'h8000_0000);
    chk("add_ovf", Overflow, 1);
    chk("add_zero", Zero, 0);
    chk("add_rd", rd_out, 3);
    @(negedge clk); #1;
    chk("add_one_cycle", out_valid, 0);

    send(3'd1, 32'd5, 32'd5, 5'd4);
    chk("sub_result", ALUResult, 0);
    chk("sub_zero", Zero, 1);
    send(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
    chk("slt_result", ALUResult, 1);
    @(negedge clk); #1;

    // back-pressure
    out_ready = 0;
    send(3'd2, 32'hF0, 32'h3C, 5'd1);
    send(3'd3, 32'hF0, 32'h0F, 5'd2);
    chk("bp_full", in_ready, 0);
    ALUControl = 3'd0; SrcA = 2; SrcB = 3; rd_in = 5'd7; in_valid = 1;
    @(negedge clk); @(negedge clk); #1;
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_head0", ALUResult, 32'h30);
    chk("bp_tag0", rd_out, 1);
    out_ready = 1;
    @(negedge clk); #1;
    chk("bp_head1", ALUResult, 32'hFF);
    chk("bp_tag1", rd_out, 2);
    @(negedge clk); #1;
    in_valid = 0;
    chk("bp_head2", ALUResult, 32'd5);
    chk("bp_tag2", rd_out, 7);
    @(negedge clk); #1;

    // streaming, one per cycle, pointers wrap several times
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      ALUControl = 3'd0; SrcA = i; SrcB = i * 16; rd_in = 5'(i + 10);
      chk("stream_ready", in_ready, 1);
      @(negedge clk); #1;
      chk("stream_result", ALUResult, i * 17);
    end
    in_valid = 0;
    @(negedge clk); #1;

    // illegal op
    send(3'd6, 32'h1234, 32'h5, 5'd9);
    chk("ill_result", ALUResult, 0);
    chk("ill_zero", Zero, 1);
    chk("ill_cnt", illegal_cnt, 1);
    @(negedge clk); #1;

    // flush with buffer full and in_valid high
    out_ready = 0;
    send(3'd0, 32'd1, 32'd1, 5'd1);
    send(3'd3, 32'd2, 32'd4, 5'd2);
    flush = 1; ALUControl = 3'd7; in_valid = 1;
    @(negedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    chk("flush_cnt", illegal_cnt, 1);
    // flush with room: the illegal op would be accepted, but is dropped and not counted
    send(3'd0, 32'd8, 32'd8, 5'd3);
    flush = 1; ALUControl = 3'd4; in_valid = 1;
    @(negedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_cnt", illegal_cnt, 1);

    // saturation of illegal counter
    out_ready = 1; in_valid = 1; ALUControl = 3'd4;
    for (int i = 0; i < 260; i++) @(negedge clk);
    #1; in_valid = 0;
    chk("sat_cnt", illegal_cnt, 8'hFF);
    @(negedge clk); #1;

    // async reset while full
    out_ready = 0;
    send(3'd0, 32'd1, 32'd2, 5'd1);
    send(3'd0, 32'd3, 32'd4, 5'd2);
    chk("pre_rst_full", in_ready, 0);
    #2 rst = 0; #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_cnt", illegal_cnt, 0);
    chk("arst_result", ALUResult, 0);
    @(negedge clk); #1; rst = 1;
    @(negedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
